ts_packet_sender: RTL and testbench

TS_PACKET_SENDER -- requirements
Module: ts_packet_sender

---
 rtl/ts_packet_sender.sv | 87 ++++++++
 tb/tb_ts_packet_sender.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_sender.sv
// ts_packet_sender: paces 188-byte TS packets out of a FIFO onto a byte-clocked parallel TS port,
// filling gaps with null packets when enabled.
module ts_packet_sender #(
    parameter int DIV     = 8,
    parameter bit NULL_EN = 1'b1
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        GOT_FULL_PACKET,
    input  logic [7:0]  DATA_IN,
    output logic        RD_REQ,
    output logic [7:0]  TS_DATA,
    output logic        TS_DCLK,
    output logic        TS_VALID,
    output logic        TS_PSYNC,
    output logic [31:0] PKT_COUNT,
    output logic [31:0] NULL_COUNT,
    output logic        SYNC_ERR
);
    localparam int CW = $clog2(DIV);
    typedef enum logic [1:0] {IDLE, REAL, NULLP} state_t;
    state_t      r_state, r_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]  r_idx, r_data;
    logic        r_dclk, r_valid, r_psync, r_serr;
    logic [31:0] r_pkt, r_null;
    logic [CW-1:0] w_cnt_nxt;
    logic        w_last_cnt, w_dec_cnt, w_decide;
    state_t      w_choice, w_new_state;
    logic [7:0]  w_new_idx, w_null_byte;
    always_comb begin
        w_last_cnt  = r_cnt == CW'(DIV - 1);
        w_dec_cnt   = r_cnt == CW'(DIV - 2);
        w_cnt_nxt   = w_last_cnt ? '0 : r_cnt + 1'b1;
        w_decide    = r_state == IDLE || r_idx == 8'd187;
        w_choice    = GOT_FULL_PACKET ? REAL : (NULL_EN ? NULLP : IDLE);
        w_new_state = w_decide ? r_next : r_state;
        w_new_idx   = w_decide ? 8'd0 : r_idx + 8'd1;
        w_null_byte = w_new_idx == 8'd0 ? 8'h47 : w_new_idx == 8'd1 ? 8'h1F : w_new_idx == 8'd3 ? 8'h10 : 8'hFF;
    end
    // The strobe is issued in the decision cycle itself, so it follows GOT_FULL_PACKET directly.
    assign RD_REQ = w_dec_cnt && ((w_decide && GOT_FULL_PACKET) || (r_state == REAL && r_idx != 8'd187));
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_next  <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_dclk  <= 1'b0;
            r_valid <= 1'b0;
            r_psync <= 1'b0;
            r_serr  <= 1'b0;
            r_pkt   <= '0;
            r_null  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dclk <= w_cnt_nxt >= CW'(DIV / 2);
            r_serr <= 1'b0;
            if (w_dec_cnt && w_decide)
                r_next <= w_choice;
            if (w_last_cnt) begin
                r_state <= w_new_state;
                r_idx   <= w_new_idx;
                r_valid <= w_new_state != IDLE;
                r_psync <= w_new_state != IDLE && w_new_idx == 8'd0;
                if (w_new_state == REAL)
                    r_data <= DATA_IN;
                else if (w_new_state == NULLP)
                    r_data <= w_null_byte;
                if (w_new_state == REAL && w_new_idx == 8'd0) begin
                    r_pkt  <= r_pkt + 32'd1;
                    r_serr <= DATA_IN != 8'h47;
                end
                if (w_new_state == NULLP && w_new_idx == 8'd0)
                    r_null <= r_null + 32'd1;
            end
        end
    end
    assign TS_DATA    = r_data;
    assign TS_DCLK    = r_dclk;
    assign TS_VALID   = r_valid;
    assign TS_PSYNC   = r_psync;
    assign PKT_COUNT  = r_pkt;
    assign NULL_COUNT = r_null;
    assign SYNC_ERR   = r_serr;
endmodule

// File: tb/tb_ts_packet_sender.sv
// tb_ts_packet_sender: slot-level queue model of the TS output stream checked every cycle,
// plus directed literal checks for null bytes, sync error, counters, reset and NULL_EN=0.
module tb_ts_packet_sender;
    localparam int DIV = 8;
    localparam int PKT = 188;
    localparam bit NULL_EN = 1'b1;
    logic        SYS_CLK = 1'b0, RST = 1'b0, GOT_FULL_PACKET = 1'b0;
    logic [7:0]  DATA_IN = 8'h00;
    logic        RD_REQ, TS_DCLK, TS_VALID, TS_PSYNC, SYNC_ERR;
    logic [7:0]  TS_DATA;
    logic [31:0] PKT_COUNT, NULL_COUNT;
    logic [7:0]  nn_din = 8'h47;
    logic        nn_rd, nn_dclk, nn_valid, nn_psync, nn_serr;
    logic [7:0]  nn_data;
    logic [31:0] nn_pkt, nn_null;

    ts_packet_sender #(.DIV(DIV), .NULL_EN(NULL_EN)) u_dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(GOT_FULL_PACKET), .DATA_IN(DATA_IN),
        .RD_REQ(RD_REQ), .TS_DATA(TS_DATA), .TS_DCLK(TS_DCLK), .TS_VALID(TS_VALID),
        .TS_PSYNC(TS_PSYNC), .PKT_COUNT(PKT_COUNT), .NULL_COUNT(NULL_COUNT), .SYNC_ERR(SYNC_ERR));

    ts_packet_sender #(.DIV(DIV), .NULL_EN(1'b0)) u_nn (
        .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(GOT_FULL_PACKET), .DATA_IN(nn_din),
        .RD_REQ(nn_rd), .TS_DATA(nn_data), .TS_DCLK(nn_dclk), .TS_VALID(nn_valid),
        .TS_PSYNC(nn_psync), .PKT_COUNT(nn_pkt), .NULL_COUNT(nn_null), .SYNC_ERR(nn_serr));

    always #5 SYS_CLK = ~SYS_CLK;

    logic [7:0] src [0:3*PKT-1];
    int fp = 0;
    always @(posedge SYS_CLK)
        if (RD_REQ && fp < 3*PKT) begin
            DATA_IN <= src[fp];
            fp <= fp + 1;
        end

    typedef struct packed {logic [7:0] d; logic r; logic s;} slot_t;
    slot_t q[$];
    slot_t sl;
    int mp = 0, m_cnt = 0;
    logic [7:0] e_data = 8'h00;
    logic e_valid = 1'b0, e_psync = 1'b0, e_serr = 1'b0, e_rd;
    int e_pkt = 0, e_null = 0;
    int checks = 0, errors = 0;
    int rd_cnt = 0, serr_cnt = 0, nn_rd_cnt = 0, nn_val_cnt = 0;
    bit nn_watch = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] nbyte(input int i);
        return i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 3 ? 8'h10 : 8'hFF;
    endfunction

    always @(negedge SYS_CLK) begin
        if (!RST) begin
            chk("rst_data", TS_DATA, 0);
            chk("rst_dclk", TS_DCLK, 0);
            chk("rst_valid", TS_VALID, 0);
            chk("rst_psync", TS_PSYNC, 0);
            chk("rst_rd", RD_REQ, 0);
            chk("rst_serr", SYNC_ERR, 0);
            chk("rst_pkt", PKT_COUNT, 0);
            chk("rst_null", NULL_COUNT, 0);
            q.delete();
            m_cnt = 1;
            e_data = 8'h00; e_valid = 1'b0; e_psync = 1'b0; e_serr = 1'b0;
            e_pkt = 0; e_null = 0;
        end else begin
            if (m_cnt == DIV-2 && q.size() == 0) begin
                if (GOT_FULL_PACKET)
                    for (int i = 0; i < PKT; i++) begin
                        q.push_back('{d: src[mp], r: 1'b1, s: (i == 0)});
                        mp++;
                    end
                else if (NULL_EN)
                    for (int i = 0; i < PKT; i++)
                        q.push_back('{d: nbyte(i), r: 1'b0, s: (i == 0)});
            end
            e_rd = m_cnt == DIV-2 && q.size() > 0 && q[0].r;
            chk("m_rd", RD_REQ, e_rd);
            chk("m_dclk", TS_DCLK, m_cnt >= DIV/2);
            chk("m_data", TS_DATA, e_data);
            chk("m_valid", TS_VALID, e_valid);
            chk("m_psync", TS_PSYNC, e_psync);
            chk("m_serr", SYNC_ERR, e_serr);
            chk("m_pkt", PKT_COUNT, e_pkt);
            chk("m_null", NULL_COUNT, e_null);
            rd_cnt += int'(RD_REQ);
            serr_cnt += int'(SYNC_ERR);
            if (nn_watch) begin
                nn_rd_cnt += int'(nn_rd);
                nn_val_cnt += int'(nn_valid);
            end
            e_serr = 1'b0;
            if (m_cnt == DIV-1) begin
                if (q.size() > 0) begin
                    sl = q.pop_front();
                    e_data = sl.d;
                    e_valid = 1'b1;
                    e_psync = sl.s;
                    if (sl.s && sl.r) begin
                        e_pkt++;
                        e_serr = sl.d != 8'h47;
                    end else if (sl.s)
                        e_null++;
                end else begin
                    e_valid = 1'b0;
                    e_psync = 1'b0;
                end
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    task automatic wait_psync(output bit ok);
        logic prev = TS_PSYNC;
        ok = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            @(negedge SYS_CLK);
            if (TS_PSYNC && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = TS_PSYNC;
        end
    endtask

    initial begin
        bit ok;
        int n;
        src[0] = 8'h47;
        for (int i = 1; i < PKT; i++) src[i] = 8'(i - 1);
        src[PKT] = 8'h12;
        for (int i = PKT+1; i < 2*PKT; i++) src[i] = 8'(i * 7);
        src[2*PKT] = 8'h47;
        for (int i = 2*PKT+1; i < 3*PKT; i++) src[i] = 8'(i * 3);
        nn_watch = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        #1 RST = 1'b1;
        wait_psync(ok);
        chk("null1_found", ok, 1);
        for (int k = 0; k < 4; k++) begin
            chk("null_byte", TS_DATA, nbyte(k));
            repeat (DIV) @(negedge SYS_CLK);
        end
        chk("null1_count", NULL_COUNT, 1);
        nn_watch = 1'b0;
        chk("nn_idle_rd", nn_rd_cnt, 0);
        chk("nn_idle_valid", nn_val_cnt, 0);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2*DIV; i++) begin
            @(negedge SYS_CLK);
            if (nn_psync) begin
                ok = 1'b1;
                break;
            end
        end
        chk("nn_start", ok, 1);
        chk("nn_valid", nn_valid, 1);
        chk("nn_pkt", nn_pkt, 1);
        wait_psync(ok);
        chk("realA_found", ok, 1);
        chk("realA_byte0", TS_DATA, 8'h47);
        chk("realA_pkt", PKT_COUNT, 1);
        n = 0;
        while (!TS_DCLK && n < 2*DIV) begin
            @(negedge SYS_CLK);
            n++;
        end
        chk("dclk_rise_cnt", n, DIV/2);
        repeat (50*DIV) @(negedge SYS_CLK);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b0;
        repeat (50*DIV) @(negedge SYS_CLK);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b1;
        wait_psync(ok);
        chk("realB_found", ok, 1);
        chk("realB_byte0", TS_DATA, 8'h12);
        chk("realB_serr", SYNC_ERR, 1);
        chk("realB_pkt", PKT_COUNT, 2);
        chk("realB_rd", rd_cnt, PKT + 1);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b0;
        wait_psync(ok);
        chk("null2_found", ok, 1);
        chk("null2_count", NULL_COUNT, 2);
        chk("null2_rd", rd_cnt, 2*PKT);
        repeat (100*DIV) @(negedge SYS_CLK);
        @(posedge SYS_CLK); #1 RST = 1'b0;
        @(negedge SYS_CLK);
        chk("midrst_valid", TS_VALID, 0);
        chk("midrst_pkt", PKT_COUNT, 0);
        chk("midrst_null", NULL_COUNT, 0);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b1;
        @(negedge SYS_CLK); #1 RST = 1'b1;
        wait_psync(ok);
        chk("realC_found", ok, 1);
        chk("realC_byte0", TS_DATA, 8'h47);
        chk("realC_pkt", PKT_COUNT, 1);
        chk("realC_null", NULL_COUNT, 0);
        @(posedge SYS_CLK); #1 GOT_FULL_PACKET = 1'b0;
        repeat (190*DIV) @(negedge SYS_CLK);
        chk("end_null", NULL_COUNT, 1);
        chk("end_rd", rd_cnt, 3*PKT);
        chk("end_serr", serr_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
